mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory port between instruction fetch (IF) and the LSU.
//  Uses a req/gnt/rvalid protocol with at most one outstanding transaction and a locked owner.
//  Sits between the IF/LSU stages and the memory bus. if_blocked_o feeds the PCU as a fetch-stall hint.
// PARAMETERS
//  MEM_ADDR_W  32  memory byte-address width
//  MEM_DATA_W  32  memory data width; byte-enable width = MEM_DATA_W/8
//  STARVE_MAX  4   consecutive LSU wins tolerated while IF waits (used only with macro)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           reset; one clock, synchronous, active-high
//  if_req_i      in   1           fetch request; held with if_addr_i until if_gnt_o
//  if_addr_i     in   MEM_ADDR_W  fetch address
//  if_gnt_o      out  1           fetch request accepted this cycle
//  if_rvalid_o   out  1           fetch data valid on rdata_o
//  if_blocked_o  out  1           if_req_i & !if_gnt_o (combinational)
//  lsu_req_i     in   1           LSU request; held with all lsu_* until lsu_gnt_o
//  lsu_we_i      in   1           1 = store
//  lsu_be_i      in   DATA_W/8    byte enables
//  lsu_addr_i    in   MEM_ADDR_W  LSU address
//  lsu_wdata_i   in   MEM_DATA_W  store data
//  lsu_gnt_o     out  1           LSU request accepted this cycle
//  lsu_rvalid_o  out  1           LSU response valid (loads and stores)
//  rdata_o       out  MEM_DATA_W  mem_rdata_i broadcast to both requesters
//  mem_req_o     out  1           bus request
//  mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o   out  bus command from selected owner (IF: we=0, be='1)
//  mem_gnt_i     in   1           bus accepted request
//  mem_rvalid_i  in   1           bus response valid
//  mem_rdata_i   in   MEM_DATA_W  bus read data
// BEHAVIOUR
//  States: IDLE (nothing pending), ADDR (mem_req_o held, awaiting gnt), DATA (awaiting rvalid).
//  Registers: state, owner (IF/LSU).
//  Arbitration happens in IDLE, and in DATA during the cycle mem_rvalid_i=1. Priority is LSU > IF.
//  Winner drives mem_* combinationally in the same cycle, so request latency is 0 cycles.
//  IDLE: any req -> mem_req_o=1; gnt -> DATA, else ADDR. Owner latched. No req -> stay IDLE.
//  ADDR: owner locked. mem_* driven from owner even if the other side now requests. gnt -> DATA.
//  DATA: mem_req_o=0 until rvalid. rvalid -> owner's *_rvalid_o=1 that cycle.
//    If a request is also present, it is issued that same cycle (back-to-back); else -> IDLE.
//  x_gnt_o = mem_req_o & mem_gnt_i & (selected==x). x_rvalid_o = mem_rvalid_i & DATA & owner==x.
//  mem_rvalid_i in IDLE/ADDR is ignored; no *_rvalid_o.
//  mem_gnt_i without mem_req_o is ignored.
//  Reset: state=IDLE, owner=IF. While rst=1, mem_req_o and all *_gnt_o/*_rvalid_o are forced 0.
//  Reset mid-transaction drops the transaction. Its late rvalid lands in IDLE and is ignored.
//  Simultaneous if_req_i & lsu_req_i -> LSU wins. IF is served at the next arbitration point.
// CONFIGURATION
//  MEM_ARB_STARVE_GUARD_EN defined:
//    Saturating counter starve_cnt (reset 0).
//    +1 on each LSU win while if_req_i=1; cleared on any IF win.
//    Arbitration with starve_cnt==STARVE_MAX and if_req_i=1 -> IF wins.
//  Not defined: strict LSU priority, no counter, STARVE_MAX unused.
// STRUCTURE
//  ctrl_typedefs: mem_owner_e {OWN_IF, OWN_LSU}; arb_state_e {ARB_IDLE, ARB_ADDR, ARB_DATA}.
//  Sub-module arb_starve_counter (counter + force_if output), instantiated only under the macro.
// TESTING
//  1 IF only, gnt same cycle, rvalid +1 at 0xA5A5_0000 -> if_gnt_o@t0, if_rvalid_o@t1, rdata_o=0xA5A5_0000.
//  2 if_req & lsu_req same cycle (store 0x100, be=4'b0011) -> mem_we_o=1, lsu_gnt_o first.
//    if_gnt_o only in the rvalid cycle (back-to-back issue).
//  3 LSU request, gnt held low 3 cycles, IF requests meanwhile -> mem_addr_o stays LSU address.
//    ADDR state persists, no if_gnt_o until LSU rvalid.
//  4 rst=1 during DATA, stale mem_rvalid_i 2 cycles later -> no *_rvalid_o, state IDLE, mem_req_o=0 under rst.
//  5 Macro on, STARVE_MAX=4, LSU requests continuously with IF requesting -> IF wins on 5th arbitration.
//    Macro off -> IF never granted.
//  6 Spurious mem_rvalid_i in IDLE -> if_rvalid_o=lsu_rvalid_o=0. if_blocked_o=1 whenever if_req_i waits.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: request owner and arbiter state.
package mem_port_arbiter_pkg;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } mem_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Starvation guard for the memory-port arbiter: counts LSU wins while IF waits and
// forces the next arbitration to IF once the count reaches STARVE_MAX.
module arb_starve_counter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_fire_i,  // an arbitration produced a winner this cycle
    input  logic lsu_win_i,   // winner was the LSU
    input  logic if_req_i,
    output logic force_if_o
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Saturating count of LSU wins taken while IF was waiting; any IF win clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (arb_fire_i) begin
            if (!lsu_win_i) begin
                cnt_d = '0;
            end else if (if_req_i && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Override LSU priority once IF has waited through STARVE_MAX LSU wins.
    always_comb begin
        force_if_o = if_req_i && (cnt_q == CntMax);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one req/gnt/rvalid memory port between instruction fetch and the LSU.
// One outstanding transaction; owner is locked from issue until its response returns.
// Optional starvation guard for IF is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 32,
    parameter int unsigned MEM_DATA_W = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [MEM_ADDR_W-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic                    if_blocked_o,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [MEM_DATA_W/8-1:0] lsu_be_i,
    input  logic [MEM_ADDR_W-1:0]   lsu_addr_i,
    input  logic [MEM_DATA_W-1:0]   lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [MEM_DATA_W-1:0]   rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MEM_DATA_W/8-1:0] mem_be_o,
    output logic [MEM_ADDR_W-1:0]   mem_addr_o,
    output logic [MEM_DATA_W-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [MEM_DATA_W-1:0]   mem_rdata_i
);

    arb_state_e state_q, state_d;
    mem_owner_e owner_q, owner_d;
    mem_owner_e sel;
    logic       arb_en;
    logic       issue;
    logic       force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .arb_fire_i (issue && !rst),
        .lsu_win_i  (sel == OWN_LSU),
        .if_req_i   (if_req_i),
        .force_if_o (force_if)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign force_if = 1'b0;
`endif

    // Arbitration point and selected owner: fresh pick when arbitrating, else locked owner.
    always_comb begin
        arb_en = (state_q == ARB_IDLE) || ((state_q == ARB_DATA) && mem_rvalid_i);
        issue  = arb_en && (if_req_i || lsu_req_i);
        sel    = owner_q;
        if (arb_en) begin
            sel = (lsu_req_i && !force_if) ? OWN_LSU : OWN_IF;
        end
    end

    // Next-state logic; a new issue (from IDLE or back-to-back in DATA) overrides the rest.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ARB_ADDR: if (mem_gnt_i)    state_d = ARB_DATA;
            ARB_DATA: if (mem_rvalid_i) state_d = ARB_IDLE;
            default:                    state_d = ARB_IDLE;
        endcase
        if (issue) begin
            owner_d = sel;
            state_d = mem_gnt_i ? ARB_DATA : ARB_ADDR;
        end
    end

    // State and owner registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Bus command from the selected owner plus handshakes back to the requesters.
    always_comb begin
        mem_req_o = !rst && ((state_q == ARB_ADDR) || issue);
        if (sel == OWN_LSU) begin
            mem_we_o    = lsu_we_i;
            mem_be_o    = lsu_be_i;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = lsu_wdata_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = '1;
            mem_addr_o  = if_addr_i;
            mem_wdata_o = '0;
        end
        if_gnt_o     = mem_req_o && mem_gnt_i && (sel == OWN_IF);
        lsu_gnt_o    = mem_req_o && mem_gnt_i && (sel == OWN_LSU);
        if_rvalid_o  = !rst && mem_rvalid_i && (state_q == ARB_DATA) && (owner_q == OWN_IF);
        lsu_rvalid_o = !rst && mem_rvalid_i && (state_q == ARB_DATA) && (owner_q == OWN_LSU);
        if_blocked_o = if_req_i && !if_gnt_o;
        rdata_o      = mem_rdata_i;
    end

endmodule
